// File: rtl/uart_csr_bank_if.sv
// CSR host port of the UART register bank: one write channel and one
// read channel with a single-cycle read response.
interface uart_csr_bank_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wen;
    logic [ADDR_W-1:0] rd_addr;
    logic              ren;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;

    modport master (
        output wr_addr, wr_data, wen, rd_addr, ren,
        input  rd_data, rd_valid, rd_err
    );

    modport slave (
        input  wr_addr, wr_data, wen, rd_addr, ren,
        output rd_data, rd_valid, rd_err
    );
endinterface

// File: rtl/uart_csr_bank.sv
// Multi-channel UART CSR bank: per-channel BAUD/CTRL/IRQ_EN registers,
// sticky error status (read-clear / W1C) and a level interrupt per channel.
module uart_csr_bank #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DATA_W      = 16,
    parameter logic [15:0] BAUD_RST    = 16'd325,
    parameter bit          CLR_ON_READ = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_csr_bank_if.slave           csr,
    input  logic [NUM_CH-1:0]        parity_error,
    input  logic [NUM_CH-1:0]        frame_error,
    input  logic [NUM_CH-1:0]        overrun,
    input  logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH*DATA_W-1:0] baud_div,
    output logic [NUM_CH*9-1:0]      ctrl,
    output logic [NUM_CH-1:0]        irq
);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CTRL_W = 9;
    localparam int unsigned STK_W  = 4;

    localparam logic [1:0] REG_BAUD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

    localparam logic [CTRL_W-1:0] CTRL_RST = 9'h188;

    logic [DATA_W-1:0] baud_q   [NUM_CH];
    logic [DATA_W-1:0] baud_d   [NUM_CH];
    logic [CTRL_W-1:0] ctrl_q   [NUM_CH];
    logic [CTRL_W-1:0] ctrl_d   [NUM_CH];
    logic [STK_W-1:0]  irq_en_q [NUM_CH];
    logic [STK_W-1:0]  irq_en_d [NUM_CH];
    // sticky_q[k] holds STATUS[k+1]
    logic [STK_W-1:0]  sticky_q [NUM_CH];
    logic [STK_W-1:0]  sticky_d [NUM_CH];
    logic [STK_W-1:0]  stk_set  [NUM_CH];
    logic [STK_W-1:0]  stk_clr  [NUM_CH];

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;

    logic [CH_W-1:0]   wr_ch, rd_ch;
    logic [1:0]        wr_reg, rd_reg;
    logic              unused_wr_hi;

    assign wr_ch  = csr.wr_addr[CH_W+1:2];
    assign wr_reg = csr.wr_addr[1:0];
    assign rd_ch  = csr.rd_addr[CH_W+1:2];
    assign rd_reg = csr.rd_addr[1:0];
    assign unused_wr_hi = ^csr.wr_data[DATA_W-1:CTRL_W];

    // Register writes and sticky update; channel match only exists for ch < NUM_CH.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            baud_d[i]   = baud_q[i];
            ctrl_d[i]   = ctrl_q[i];
            irq_en_d[i] = irq_en_q[i];
            stk_clr[i]  = '0;
            stk_set[i]  = {(ctrl_q[i][3:0] < 4'd5) || (ctrl_q[i][3:0] > 4'd8),
                           overrun[i], frame_error[i], parity_error[i]};
            if (csr.wen && (wr_ch == CH_W'(i))) begin
                case (wr_reg)
                    REG_BAUD:   baud_d[i]   = csr.wr_data;
                    REG_CTRL:   ctrl_d[i]   = csr.wr_data[CTRL_W-1:0];
                    REG_STATUS: stk_clr[i]  = csr.wr_data[4:1];
                    default:    irq_en_d[i] = csr.wr_data[4:1];
                endcase
            end
            if (CLR_ON_READ && csr.ren && (rd_ch == CH_W'(i)) && (rd_reg == REG_STATUS)) begin
                stk_clr[i] = '1;
            end
            sticky_d[i] = (sticky_q[i] & ~stk_clr[i]) | stk_set[i];
        end
    end

    // Read mux samples pre-write state; unmatched channel returns zero with error.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = csr.ren;
        rd_err_d   = rd_err_q;
        if (csr.ren) begin
            rd_data_d = '0;
            rd_err_d  = 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (rd_ch == CH_W'(i)) begin
                    rd_err_d = 1'b0;
                    case (rd_reg)
                        REG_BAUD:   rd_data_d = baud_q[i];
                        REG_CTRL:   rd_data_d = DATA_W'(ctrl_q[i]);
                        REG_STATUS: rd_data_d = DATA_W'({sticky_q[i], busy[i]});
                        default:    rd_data_d = DATA_W'({irq_en_q[i], 1'b0});
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                baud_q[i]   <= DATA_W'(BAUD_RST);
                ctrl_q[i]   <= CTRL_RST;
                irq_en_q[i] <= '0;
                sticky_q[i] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                baud_q[i]   <= baud_d[i];
                ctrl_q[i]   <= ctrl_d[i];
                irq_en_q[i] <= irq_en_d[i];
                sticky_q[i] <= sticky_d[i];
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign csr.rd_data  = rd_data_q;
    assign csr.rd_valid = rd_valid_q;
    assign csr.rd_err   = rd_err_q;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch_out
        assign baud_div[g*DATA_W +: DATA_W] = baud_q[g];
        assign ctrl[g*CTRL_W +: CTRL_W]     = ctrl_q[g];
        assign irq[g]                       = |(sticky_q[g] & irq_en_q[g]);
    end
endmodule

// File: tb/tb_uart_csr_bank.sv
// Directed bench for uart_csr_bank: a 2-channel instance for the main
// function and a 3-channel instance for out-of-range channel handling.
module tb_uart_csr_bank;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [1:0]  pe2, fe2, ov2, busy2, irq2;
    logic [31:0] baud_div2;
    logic [17:0] ctrl2;
    logic [2:0]  pe3, fe3, ov3, busy3, irq3;
    logic [47:0] baud_div3;
    logic [26:0] ctrl3;

    logic [15:0] d;
    logic        v, e;

    uart_csr_bank_if #(.ADDR_W(3), .DATA_W(16)) i2 ();
    uart_csr_bank_if #(.ADDR_W(4), .DATA_W(16)) i3 ();

    uart_csr_bank #(.NUM_CH(2)) dut (
        .clk(clk), .rst_n(rst_n), .csr(i2),
        .parity_error(pe2), .frame_error(fe2), .overrun(ov2), .busy(busy2),
        .baud_div(baud_div2), .ctrl(ctrl2), .irq(irq2)
    );

    uart_csr_bank #(.NUM_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .csr(i3),
        .parity_error(pe3), .frame_error(fe3), .overrun(ov3), .busy(busy3),
        .baud_div(baud_div3), .ctrl(ctrl3), .irq(irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic rd2(input logic [2:0] a, output logic [15:0] od, output logic ov, output logic oe);
        @(negedge clk); i2.rd_addr = a; i2.ren = 1'b1;
        @(negedge clk); i2.ren = 1'b0;
        od = i2.rd_data; ov = i2.rd_valid; oe = i2.rd_err;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [15:0] wd);
        @(negedge clk); i2.wr_addr = a; i2.wr_data = wd; i2.wen = 1'b1;
        @(negedge clk); i2.wen = 1'b0;
    endtask

    task automatic rd3(input logic [3:0] a, output logic [15:0] od, output logic ov, output logic oe);
        @(negedge clk); i3.rd_addr = a; i3.ren = 1'b1;
        @(negedge clk); i3.ren = 1'b0;
        od = i3.rd_data; ov = i3.rd_valid; oe = i3.rd_err;
    endtask

    task automatic wr3(input logic [3:0] a, input logic [15:0] wd);
        @(negedge clk); i3.wr_addr = a; i3.wr_data = wd; i3.wen = 1'b1;
        @(negedge clk); i3.wen = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (i2.rd_valid !== 1'b0 || i2.rd_data !== 16'h0 || i2.rd_err !== 1'b0) begin
            fails++; $display("FAIL reset_rd: valid=%b data=%h err=%b, want 0/0000/0", i2.rd_valid, i2.rd_data, i2.rd_err); end
        tests++; if (irq2 !== 2'b00) begin fails++; $display("FAIL reset_irq: got %b want 00", irq2); end
        tests++; if (baud_div2 !== {16'd325, 16'd325}) begin
            fails++; $display("FAIL reset_baud_div: got %h want %h", baud_div2, {16'd325, 16'd325}); end
        tests++; if (ctrl2 !== {9'h188, 9'h188}) begin
            fails++; $display("FAIL reset_ctrl: got %h want %h", ctrl2, {9'h188, 9'h188}); end
        @(negedge clk); rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            case (a % 4)
                0:       exp = 16'd325;
                1:       exp = 16'h0188;
                default: exp = 16'h0000;
            endcase
            rd2(3'(a), d, v, e);
            tests++; if (v !== 1'b1 || e !== 1'b0 || d !== exp) begin
                fails++; $display("FAIL reset_read addr %0d: data=%h valid=%b err=%b, want %h/1/0", a, d, v, e, exp); end
        end
        @(negedge clk);
        tests++; if (i2.rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_pulse: got %b want 0", i2.rd_valid); end
    endtask

    task automatic test_baud_write();
        wr2(3'b100, 16'h00A2);
        tests++; if (baud_div2 !== {16'h00A2, 16'd325}) begin
            fails++; $display("FAIL baud_div_after_write: got %h want %h", baud_div2, {16'h00A2, 16'd325}); end
        rd2(3'b000, d, v, e);
        tests++; if (d !== 16'd325 || v !== 1'b1) begin fails++; $display("FAIL baud_ch0: got %h want %h", d, 16'd325); end
        rd2(3'b100, d, v, e);
        tests++; if (d !== 16'h00A2 || v !== 1'b1) begin fails++; $display("FAIL baud_ch1: got %h want 00a2", d); end
    endtask

    task automatic test_reg_masks();
        wr2(3'b111, 16'hFFFF);
        rd2(3'b111, d, v, e);
        tests++; if (d !== 16'h001E) begin fails++; $display("FAIL irq_en_mask: got %h want 001e", d); end
        wr2(3'b111, 16'h0000);
        wr2(3'b101, 16'hFE88);
        tests++; if (ctrl2[17:9] !== 9'h088) begin fails++; $display("FAIL ctrl_port_mask: got %h want 088", ctrl2[17:9]); end
        rd2(3'b101, d, v, e);
        tests++; if (d !== 16'h0088) begin fails++; $display("FAIL ctrl_read_mask: got %h want 0088", d); end
        wr2(3'b101, 16'h0188);
    endtask

    task automatic test_busy();
        busy2 = 2'b01;
        rd2(3'b010, d, v, e);
        tests++; if (d !== 16'h0001) begin fails++; $display("FAIL busy_live: got %h want 0001", d); end
        tests++; if (irq2 !== 2'b00) begin fails++; $display("FAIL busy_no_irq: got %b want 00", irq2); end
        busy2 = 2'b00;
        rd2(3'b010, d, v, e);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL busy_drop: got %h want 0000", d); end
    endtask

    task automatic test_parity_irq();
        wr2(3'b011, 16'h0002);
        @(negedge clk); pe2 = 2'b01;
        @(negedge clk); pe2 = 2'b00;
        tests++; if (irq2 !== 2'b01) begin fails++; $display("FAIL parity_irq_rise: got %b want 01", irq2); end
        rd2(3'b010, d, v, e);
        tests++; if (d !== 16'h0002) begin fails++; $display("FAIL parity_status: got %h want 0002", d); end
        tests++; if (irq2 !== 2'b00) begin fails++; $display("FAIL parity_irq_drop: got %b want 00", irq2); end
        rd2(3'b010, d, v, e);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL parity_read_clear: got %h want 0000", d); end
    endtask

    task automatic test_set_beats_clear();
        wr2(3'b111, 16'h0004);
        @(negedge clk); fe2 = 2'b10; i2.wr_addr = 3'b110; i2.wr_data = 16'h0004; i2.wen = 1'b1;
        @(negedge clk); fe2 = 2'b00; i2.wen = 1'b0;
        tests++; if (irq2 !== 2'b10) begin fails++; $display("FAIL frame_set_beats_w1c: irq got %b want 10", irq2); end
        wr2(3'b110, 16'h0004);
        tests++; if (irq2 !== 2'b00) begin fails++; $display("FAIL frame_w1c: irq got %b want 00", irq2); end
        rd2(3'b110, d, v, e);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL frame_after_w1c: got %h want 0000", d); end
        // parity event in the same cycle as a clearing read of STATUS0
        @(negedge clk); pe2 = 2'b01; i2.rd_addr = 3'b010; i2.ren = 1'b1;
        @(negedge clk); pe2 = 2'b00; i2.ren = 1'b0;
        tests++; if (i2.rd_data !== 16'h0000 || irq2 !== 2'b01) begin
            fails++; $display("FAIL parity_set_beats_rdclr: data=%h irq=%b want 0000/01", i2.rd_data, irq2); end
        rd2(3'b010, d, v, e);
        tests++; if (d !== 16'h0002) begin fails++; $display("FAIL parity_survived: got %h want 0002", d); end
    endtask

    task automatic test_data_bits();
        wr2(3'b001, 16'h0184);
        tests++; if (ctrl2[8:0] !== 9'h184) begin fails++; $display("FAIL ctrl0_port: got %h want 184", ctrl2[8:0]); end
        for (int k = 0; k < 3; k++) begin
            wr2(3'b010, 16'h0010);
            rd2(3'b010, d, v, e);
            tests++; if (d !== 16'h0010) begin fails++; $display("FAIL data_bits_persist %0d: got %h want 0010", k, d); end
        end
        wr2(3'b001, 16'h0187);
        wr2(3'b010, 16'h0010);
        rd2(3'b010, d, v, e);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL data_bits_cleared: got %h want 0000", d); end
        wr2(3'b001, 16'h0188);
    endtask

    task automatic test_collision();
        @(negedge clk);
        i2.wr_addr = 3'b000; i2.wr_data = 16'h1234; i2.wen = 1'b1;
        i2.rd_addr = 3'b000; i2.ren = 1'b1;
        @(negedge clk); i2.wen = 1'b0; i2.ren = 1'b0;
        tests++; if (i2.rd_data !== 16'd325 || i2.rd_valid !== 1'b1) begin
            fails++; $display("FAIL rw_same_cycle: data=%h valid=%b want 0145/1", i2.rd_data, i2.rd_valid); end
        rd2(3'b000, d, v, e);
        tests++; if (d !== 16'h1234) begin fails++; $display("FAIL rw_new_value: got %h want 1234", d); end
        repeat (2) @(negedge clk);
        tests++; if (i2.rd_valid !== 1'b0 || i2.rd_data !== 16'h1234) begin
            fails++; $display("FAIL rd_data_hold: valid=%b data=%h want 0/1234", i2.rd_valid, i2.rd_data); end
    endtask

    task automatic test_out_of_range();
        rd3(4'b1000, d, v, e);
        tests++; if (d !== 16'd325 || e !== 1'b0) begin fails++; $display("FAIL ch2_baud: data=%h err=%b want 0145/0", d, e); end
        rd3(4'b1100, d, v, e);
        tests++; if (d !== 16'h0000 || v !== 1'b1 || e !== 1'b1) begin
            fails++; $display("FAIL oor_read: data=%h valid=%b err=%b want 0000/1/1", d, v, e); end
        wr3(4'b1100, 16'hBEEF);
        wr3(4'b1101, 16'h0000);
        tests++; if (baud_div3 !== {3{16'd325}} || ctrl3 !== {3{9'h188}}) begin
            fails++; $display("FAIL oor_write: baud=%h ctrl=%h want all 0145/188", baud_div3, ctrl3); end
        wr3(4'b1000, 16'h0055);
        tests++; if (baud_div3 !== {16'h0055, 16'd325, 16'd325}) begin
            fails++; $display("FAIL ch2_write: got %h want 0055_0145_0145", baud_div3); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); i2.rd_addr = 3'b100; i2.ren = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        tests++; if (i2.rd_valid !== 1'b0 || i2.rd_data !== 16'h0000) begin
            fails++; $display("FAIL mid_reset_rd: valid=%b data=%h want 0/0000", i2.rd_valid, i2.rd_data); end
        tests++; if (baud_div2 !== {16'd325, 16'd325} || baud_div3 !== {3{16'd325}}) begin
            fails++; $display("FAIL mid_reset_baud: got %h %h", baud_div2, baud_div3); end
        tests++; if (irq2 !== 2'b00) begin fails++; $display("FAIL mid_reset_irq: got %b want 00", irq2); end
        i2.ren = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rd2(3'b011, d, v, e);
        tests++; if (d !== 16'h0000) begin fails++; $display("FAIL mid_reset_irq_en: got %h want 0000", d); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        pe2 = '0; fe2 = '0; ov2 = '0; busy2 = '0;
        pe3 = '0; fe3 = '0; ov3 = '0; busy3 = '0;
        i2.wen = 1'b0; i2.ren = 1'b0; i2.wr_addr = '0; i2.wr_data = '0; i2.rd_addr = '0;
        i3.wen = 1'b0; i3.ren = 1'b0; i3.wr_addr = '0; i3.wr_data = '0; i3.rd_addr = '0;
        test_reset();
        test_baud_write();
        test_reg_masks();
        test_busy();
        test_parity_irq();
        test_set_beats_clear();
        test_data_bits();
        test_collision();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
